// File: rtl/adc_spi_pkg.sv
// Shared types and helpers for the MCP320x-class ADC scanner.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } adc_state_e;

  // Channel-select field width for n channels (1..8).
  function automatic int unsigned ch_bits(int unsigned n);
    if (n <= 2)      return 1;
    else if (n <= 4) return 2;
    else             return 3;
  endfunction

  // SCK periods per frame: start, SGL, channel, MSBF, null, data.
  function automatic int unsigned frame_len(int unsigned chb, int unsigned res);
    return chb + 4 + res;
  endfunction

  // Command bit sent on MOSI at frame bit index idx.
  function automatic logic mosi_bit(int unsigned idx, int unsigned ch, int unsigned chb);
    logic b;
    b = 1'b0;
    if (idx == 0 || idx == 1 || idx == chb + 2)
      b = 1'b1;
    else if (idx >= 2 && idx <= chb + 1)
      b = ((ch >> (chb - 1 - (idx - 2))) & 1) != 0;
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_if.sv
// SPI pin bundle between the scanner (master) and the ADC (slave).
interface adc_spi_if;
  logic SPI_SCK;
  logic SPI_AD;
  logic SPI_DIN;
  logic SPI_DOUT;

  modport master (output SPI_SCK, output SPI_AD, output SPI_DIN, input SPI_DOUT);
  modport slave  (input SPI_SCK, input SPI_AD, input SPI_DIN, output SPI_DOUT);
endinterface

// File: rtl/adc_iir_filter.sv
// Channel-multiplexed first-order IIR: y += (x - y) >>> AVG_SHIFT.
// The first sample per channel after reset loads the raw value.
module adc_iir_filter
  import adc_spi_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned RES       = 12,
  parameter int unsigned AVG_SHIFT = 2,
  parameter int unsigned CH_BITS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd,
  input  logic [CH_BITS-1:0] ch,
  input  logic [RES-1:0]     x,
  output logic [RES-1:0]     y
);

  logic [RES-1:0]    y_q [NUM_CH];
  logic [RES-1:0]    y_d [NUM_CH];
  logic [NUM_CH-1:0] primed_q, primed_d;

  logic [RES-1:0]    y_sel;
  logic              primed_sel;
  logic signed [RES:0] diff, step, sum;

  // Select the addressed channel's state and compute the filtered result.
  always_comb begin
    y_sel      = '0;
    primed_sel = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch == CH_BITS'(k)) begin
        y_sel      = y_q[k];
        primed_sel = primed_q[k];
      end
    end
    diff = $signed({1'b0, x}) - $signed({1'b0, y_sel});
    step = diff >>> AVG_SHIFT;
    sum  = $signed({1'b0, y_sel}) + step;
    y    = primed_sel ? sum[RES-1:0] : x;
  end

  // Commit the new result into the addressed channel on update.
  always_comb begin
    y_d      = y_q;
    primed_d = primed_q;
    if (upd) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (ch == CH_BITS'(k)) begin
          y_d[k]      = y;
          primed_d[k] = 1'b1;
        end
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) y_q[k] <= '0;
      primed_q <= '0;
    end else begin
      y_q      <= y_d;
      primed_q <= primed_d;
    end
  end

endmodule

// File: rtl/adc_spi_scanner.sv
// SPI master scanning NUM_CH single-ended channels of an MCP320x-class ADC.
// Optional per-channel IIR smoothing when ADC_AVG_EN is defined.
module adc_spi_scanner
  import adc_spi_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned RES     = 12,
  parameter int unsigned SCK_DIV = 25,
  parameter int unsigned CS_IDLE = 50
`ifdef ADC_AVG_EN
  ,
  parameter int unsigned AVG_SHIFT = 2
`endif
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              scan_en,
  adc_spi_if.master                         spi,
  output logic                              busy,
  output logic                              sample_valid,
  output logic [adc_spi_pkg::ch_bits(NUM_CH)-1:0] sample_ch,
  output logic [RES-1:0]                    sample_data,
  output logic [NUM_CH*RES-1:0]             ch_data
);

  localparam int unsigned CH_BITS   = ch_bits(NUM_CH);
  localparam int unsigned FRAME_LEN = frame_len(CH_BITS, RES);
  localparam int unsigned PH_W      = $clog2(SCK_DIV);
  localparam int unsigned BIT_W     = $clog2(FRAME_LEN);
  localparam int unsigned GAP_W     = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  adc_state_e          state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic [RES-1:0]      shreg_q, shreg_d;
  logic                sck_q, sck_d;
  logic                ad_q, ad_d;
  logic                din_q, din_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [CH_BITS-1:0]  sample_ch_q, sample_ch_d;
  logic [RES-1:0]      sample_data_q, sample_data_d;
  logic [NUM_CH*RES-1:0] ch_data_q, ch_data_d;
  logic                miso_s1_q, miso_s2_q;

  logic                frame_end;
  logic [RES-1:0]      result;
  logic [CH_BITS-1:0]  ch_next;

  assign ch_next = (ch_q == CH_BITS'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

`ifdef ADC_AVG_EN
  adc_iir_filter #(
    .NUM_CH    (NUM_CH),
    .RES       (RES),
    .AVG_SHIFT (AVG_SHIFT),
    .CH_BITS   (CH_BITS)
  ) u_filter (
    .clk   (CLK),
    .rst_n (RST_N),
    .upd   (frame_end),
    .ch    (ch_q),
    .x     (shreg_q),
    .y     (result)
  );
`else
  assign result = shreg_q;
`endif

  // Next-state logic: frame sequencing, SCK generation, MOSI/MISO shifting.
  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    bit_d         = bit_q;
    gap_d         = gap_q;
    ch_d          = ch_q;
    shreg_d       = shreg_q;
    sck_d         = sck_q;
    ad_d          = ad_q;
    din_d         = din_q;
    busy_d        = busy_q;
    valid_d       = 1'b0;
    sample_ch_d   = sample_ch_q;
    sample_data_d = sample_data_q;
    ch_data_d     = ch_data_q;
    frame_end     = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = SHIFT;
          ad_d    = 1'b0;
          busy_d  = 1'b1;
          sck_d   = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          din_d   = mosi_bit(0, 32'(ch_q), CH_BITS);
        end
      end
      SHIFT: begin
        if (ph_q == PH_W'(SCK_DIV - 1)) begin
          ph_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shreg_d = {shreg_q[RES-2:0], miso_s2_q};
          end else if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
            // Last data bit was captured on the preceding rise; publish now.
            frame_end     = 1'b1;
            state_d       = DONE;
            sck_d         = 1'b0;
            ad_d          = 1'b1;
            din_d         = 1'b0;
            valid_d       = 1'b1;
            sample_ch_d   = ch_q;
            sample_data_d = result;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (ch_q == CH_BITS'(k)) ch_data_d[k*RES +: RES] = result;
            end
            ch_d = ch_next;
          end else begin
            bit_d = bit_q + 1'b1;
            sck_d = 1'b0;
            din_d = mosi_bit(32'(bit_q) + 32'd1, 32'(ch_q), CH_BITS);
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DONE: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GAP_W'(CS_IDLE - 1)) begin
          if (scan_en) begin
            state_d = SHIFT;
            ad_d    = 1'b0;
            sck_d   = 1'b0;
            ph_d    = '0;
            bit_d   = '0;
            din_d   = mosi_bit(0, 32'(ch_q), CH_BITS);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      ph_q          <= '0;
      bit_q         <= '0;
      gap_q         <= '0;
      ch_q          <= '0;
      shreg_q       <= '0;
      sck_q         <= 1'b0;
      ad_q          <= 1'b1;
      din_q         <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      sample_ch_q   <= '0;
      sample_data_q <= '0;
      ch_data_q     <= '0;
      miso_s1_q     <= 1'b0;
      miso_s2_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      bit_q         <= bit_d;
      gap_q         <= gap_d;
      ch_q          <= ch_d;
      shreg_q       <= shreg_d;
      sck_q         <= sck_d;
      ad_q          <= ad_d;
      din_q         <= din_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      sample_ch_q   <= sample_ch_d;
      sample_data_q <= sample_data_d;
      ch_data_q     <= ch_data_d;
      miso_s1_q     <= spi.SPI_DOUT;
      miso_s2_q     <= miso_s1_q;
    end
  end

  assign spi.SPI_SCK  = sck_q;
  assign spi.SPI_AD   = ad_q;
  assign spi.SPI_DIN  = din_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign ch_data      = ch_data_q;

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Directed bench for adc_spi_scanner with a behavioural MCP3202-style slave.
// Define ADC_AVG_EN to also exercise the IIR filter sequence.
module tb_adc_spi_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        busy;
  logic        sample_valid;
  logic [0:0]  sample_ch;
  logic [11:0] sample_data;
  logic [23:0] ch_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  adc_spi_if spi ();

  adc_spi_scanner #(
    .NUM_CH  (2),
    .RES     (12),
    .SCK_DIV (25),
    .CS_IDLE (50)
`ifdef ADC_AVG_EN
    ,
    .AVG_SHIFT (2)
`endif
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .scan_en      (scan_en),
    .spi          (spi),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .ch_data      (ch_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural ADC slave ----------------
  logic [11:0] slave_val [2];
  int   rise_cnt   = 0;
  logic cmd_ch     = 1'b0;
  logic [3:0] hdr  = '0;
  logic [3:0] last_hdr = '0;
  int   last_rises = 0;
  int   last_rise_cyc = 0;
  int   sck_bad    = 0;
  int   ad_rise_cyc = 0;
  int   ad_hi_min  = 1000000;
  int   ad_hi_max  = 0;
  int   ad_falls   = 0;
  int   valid_cnt  = 0;

  initial spi.SPI_DOUT = 1'b0;

  always @(negedge spi.SPI_AD) begin
    rise_cnt = 0;
    ad_falls++;
    if (cyc - ad_rise_cyc < ad_hi_min) ad_hi_min = cyc - ad_rise_cyc;
    if (cyc - ad_rise_cyc > ad_hi_max) ad_hi_max = cyc - ad_rise_cyc;
  end

  always @(posedge spi.SPI_AD) begin
    last_hdr    = hdr;
    last_rises  = rise_cnt;
    ad_rise_cyc = cyc;
  end

  always @(posedge spi.SPI_SCK) begin
    if (rise_cnt > 0 && (cyc - last_rise_cyc) != 50) sck_bad++;
    last_rise_cyc = cyc;
    if (rise_cnt < 4) hdr[3 - rise_cnt] = spi.SPI_DIN;
    if (rise_cnt == 2) cmd_ch = spi.SPI_DIN;
    rise_cnt++;
  end

  always @(negedge spi.SPI_SCK) begin
    if (rise_cnt >= 5 && rise_cnt <= 16) spi.SPI_DOUT = slave_val[cmd_ch][16 - rise_cnt];
    else                                 spi.SPI_DOUT = 1'b0;
  end

  always @(negedge clk) if (sample_valid === 1'b1) valid_cnt++;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int t);
    int n = 0;
    @(negedge clk);
    while (sample_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_arrive"}, 64'(sample_valid), 64'd1);
    t = cyc;
  endtask

  task automatic wait_ad_low(input string tag, output int t);
    int n = 0;
    @(negedge clk);
    while (spi.SPI_AD !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_ad_low"}, 64'(spi.SPI_AD), 64'd0);
    t = cyc;
  endtask

  task automatic wait_rise(input string tag, input int r);
    int n = 0;
    while (rise_cnt < r && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_rise"}, 64'(rise_cnt), 64'(r));
  endtask

  int t_fall, t_v, t_prev, n_idle, falls0;

  initial begin
    slave_val[0] = 12'd1000;
    slave_val[1] = 12'd2000;
    rst_n   = 1'b0;
    scan_en = 1'b0;

    // 1: reset, idle with scan_en low
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    valid_cnt = 0;
    repeat (1000) @(negedge clk);
    chk("idle_ad",   64'(spi.SPI_AD),  64'd1);
    chk("idle_sck",  64'(spi.SPI_SCK), 64'd0);
    chk("idle_din",  64'(spi.SPI_DIN), 64'd0);
    chk("idle_busy", 64'(busy),        64'd0);
    chk("idle_vcnt", 64'(valid_cnt),   64'd0);
    chk("idle_chd",  64'(ch_data),     64'd0);
    chk("idle_sch",  64'(sample_ch),   64'd0);
    chk("idle_sdat", 64'(sample_data), 64'd0);

    // 2: first two frames
    scan_en = 1'b1;
    wait_ad_low("f0", t_fall);
    chk("f0_busy", 64'(busy), 64'd1);
    wait_valid("f0", t_v);
    chk("f0_latency", 64'(t_v - t_fall), 64'd850);
    chk("f0_ch",    64'(sample_ch),   64'd0);
    chk("f0_data",  64'(sample_data), 64'd1000);
    chk("f0_hdr",   64'(last_hdr),    64'b1101);
    chk("f0_rises", 64'(last_rises),  64'd17);
    chk("f0_ad",    64'(spi.SPI_AD),  64'd1);
    t_prev = t_v;
    wait_valid("f1", t_v);
    chk("f1_period", 64'(t_v - t_prev), 64'd901);
    chk("f1_ch",    64'(sample_ch),   64'd1);
    chk("f1_data",  64'(sample_data), 64'd2000);
    chk("f1_hdr",   64'(last_hdr),    64'b1111);
    chk("f1_rises", 64'(last_rises),  64'd17);
    chk("f1_chd",   64'(ch_data),     {40'd0, 12'd2000, 12'd1000});
    t_prev = t_v;

    // 3: continuous scan, 8 more frames
    sck_bad   = 0;
    ad_hi_min = 1000000;
    ad_hi_max = 0;
    for (int i = 0; i < 8; i++) begin
      wait_valid("scan", t_v);
      chk("scan_period", 64'(t_v - t_prev), 64'd901);
      chk("scan_ch",     64'(sample_ch),    64'(i % 2));
      chk("scan_data",   64'(sample_data),  (i % 2 == 0) ? 64'd1000 : 64'd2000);
      t_prev = t_v;
    end
    chk("scan_sck_bad", 64'(sck_bad),   64'd0);
    chk("scan_cs_min",  64'(ad_hi_min), 64'd51);
    chk("scan_cs_max",  64'(ad_hi_max), 64'd51);

    // 4: drop scan_en at rise 8 of a ch1 frame
    wait_valid("s4a", t_v);
    chk("s4a_ch", 64'(sample_ch), 64'd0);
    wait_ad_low("s4", t_fall);
    wait_rise("s4", 8);
    scan_en = 1'b0;
    wait_valid("s4b", t_v);
    chk("s4b_ch",   64'(sample_ch),   64'd1);
    chk("s4b_data", 64'(sample_data), 64'd2000);
    chk("s4b_busy_gap", 64'(busy),    64'd1);
    n_idle = 0;
    while (busy !== 1'b0 && n_idle < 200) begin @(negedge clk); n_idle++; end
    chk("s4_busy_low", 64'(busy),   64'd0);
    chk("s4_gap_len",  64'(cyc - t_v), 64'd51);
    falls0 = ad_falls;
    repeat (1000) @(negedge clk);
    chk("s4_no_frame", 64'(ad_falls), 64'(falls0));
    chk("s4_ad",       64'(spi.SPI_AD), 64'd1);

    // 5: reset mid-frame at rise 10
    scan_en = 1'b1;
    wait_ad_low("s5", t_fall);
    wait_rise("s5", 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("s5_ad",   64'(spi.SPI_AD),  64'd1);
    chk("s5_sck",  64'(spi.SPI_SCK), 64'd0);
    chk("s5_din",  64'(spi.SPI_DIN), 64'd0);
    chk("s5_busy", 64'(busy),        64'd0);
    chk("s5_chd",  64'(ch_data),     64'd0);
    rst_n = 1'b1;
    wait_ad_low("s5r", t_fall);
    wait_valid("s5r", t_v);
    chk("s5r_latency", 64'(t_v - t_fall), 64'd850);
    chk("s5r_ch",   64'(sample_ch),   64'd0);
    chk("s5r_data", 64'(sample_data), 64'd1000);

`ifdef ADC_AVG_EN
    // 6: IIR step response on ch0 (0 then 4000), ch1 constant 2000
    slave_val[0] = 12'd0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("a0", t_v);
    chk("a0_ch",   64'(sample_ch),   64'd0);
    chk("a0_data", 64'(sample_data), 64'd0);
    slave_val[0] = 12'd4000;
    for (int i = 0; i < 3; i++) begin
      wait_valid("a_ch1", t_v);
      chk("a_ch1_ch",   64'(sample_ch),   64'd1);
      chk("a_ch1_data", 64'(sample_data), 64'd2000);
      wait_valid("a_ch0", t_v);
      chk("a_ch0_ch",   64'(sample_ch),   64'd0);
      chk("a_ch0_data", 64'(sample_data), (i == 0) ? 64'd1000 : (i == 1) ? 64'd1750 : 64'd2312);
    end
    chk("a_chd", 64'(ch_data), {40'd0, 12'd2000, 12'd2312});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
